// File: rtl/timer_gen.sv
// timer_gen: parametrised up/down timer with prescaled or external-pin ticks,
// auto-reload, sticky overflow flag and direct load path.
module timer_gen #(
  parameter int WIDTH       = 16,
  parameter int PRESCALE    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             timers_clock_i,
  input  logic             timers_reset_i,
  input  logic             timers_run_i,
  input  logic             timers_gate_i,
  input  logic             timers_int_i,
  input  logic             timers_ct_i,
  input  logic             timers_t_i,
  input  logic [1:0]       timers_mode_i,
  input  logic             timers_load_we_i,
  input  logic [WIDTH-1:0] timers_load_val_i,
  input  logic [WIDTH-1:0] timers_reload_i,
  input  logic             timers_flag_clr_i,
  output logic [WIDTH-1:0] timers_count_o,
  output logic             timers_flag_o,
  output logic             timers_ovf_pulse_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic flag_q, pulse_q;
  logic enable, up, tick, wrap;
  always_comb begin
    enable = timers_run_i & (~timers_gate_i | timers_int_i);
    up = ~timers_mode_i[0];
    tick = timers_ct_i ? (sync_q[SYNC_STAGES-1] & ~prev_q & enable) : (enable & (pre_q == PRE_MAX));
    pre_d = (~enable | timers_ct_i | (pre_q == PRE_MAX)) ? {PW{1'b0}} : pre_q + 1'b1;
    wrap = ~timers_load_we_i & tick & (up ? &count_q : ~|count_q);
    count_d = timers_load_we_i ? timers_load_val_i :
              ~tick            ? count_q :
              wrap             ? (timers_mode_i[1] ? timers_reload_i : up ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) :
              up               ? count_q + 1'b1 : count_q - 1'b1;
  end
  always_ff @(posedge timers_clock_i) begin
    if (timers_reset_i) begin
      pre_q   <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], timers_t_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      count_q <= count_d;
      flag_q  <= wrap | (flag_q & ~timers_flag_clr_i);
      pulse_q <= wrap;
    end
  end
  assign timers_count_o     = count_q;
  assign timers_flag_o      = flag_q;
  assign timers_ovf_pulse_o = pulse_q;
endmodule

// File: tb/tb_timer_gen.sv
// tb_timer_gen: two timer_gen instances (PRESCALE 1/12, SYNC 2/3) on shared
// inputs, checked every cycle against a behavioural model.
module tb_timer_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, run, gate, intp, ct, tpin, we, clr;
  logic [1:0] mode;
  logic [15:0] lval, rval;
  logic [15:0] cnt0, cnt1;
  logic f0, f1, p0, p1;
  int total = 0, bad = 0;
  int ps[2] = '{1, 12};
  int ss[2] = '{2, 3};
  int m_cnt[2], m_pre[2];
  bit m_flag[2], m_pulse[2];
  bit h[2][5];
  timer_gen #(.WIDTH(16), .PRESCALE(1), .SYNC_STAGES(2)) u0 (
    .timers_clock_i(clk), .timers_reset_i(rst), .timers_run_i(run), .timers_gate_i(gate),
    .timers_int_i(intp), .timers_ct_i(ct), .timers_t_i(tpin), .timers_mode_i(mode),
    .timers_load_we_i(we), .timers_load_val_i(lval), .timers_reload_i(rval),
    .timers_flag_clr_i(clr), .timers_count_o(cnt0), .timers_flag_o(f0), .timers_ovf_pulse_o(p0));
  timer_gen #(.WIDTH(16), .PRESCALE(12), .SYNC_STAGES(3)) u1 (
    .timers_clock_i(clk), .timers_reset_i(rst), .timers_run_i(run), .timers_gate_i(gate),
    .timers_int_i(intp), .timers_ct_i(ct), .timers_t_i(tpin), .timers_mode_i(mode),
    .timers_load_we_i(we), .timers_load_val_i(lval), .timers_reload_i(rval),
    .timers_flag_clr_i(clr), .timers_count_o(cnt1), .timers_flag_o(f1), .timers_ovf_pulse_o(p1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  // Next-state of the reference model from the inputs presented this cycle.
  task automatic model();
    for (int i = 0; i < 2; i++) begin
      bit en, ext, tick;
      if (rst) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_flag[i] = 0; m_pulse[i] = 0;
        for (int k = 0; k < 5; k++) h[i][k] = 0;
        continue;
      end
      en = run && (!gate || intp);
      ext = h[i][ss[i]-1] && !h[i][ss[i]];
      tick = ct ? (ext && en) : (en && m_pre[i] == ps[i] - 1);
      m_pre[i] = (en && !ct) ? (m_pre[i] + 1) % ps[i] : 0;
      for (int k = 4; k > 0; k--) h[i][k] = h[i][k-1];
      h[i][0] = tpin;
      m_pulse[i] = 0;
      if (we) m_cnt[i] = lval;
      else if (tick) begin
        if (mode[0] == 1'b0) begin
          if (m_cnt[i] == 65535) begin m_pulse[i] = 1; m_cnt[i] = mode[1] ? rval : 0; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin m_pulse[i] = 1; m_cnt[i] = mode[1] ? rval : 65535; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
      end
      m_flag[i] = m_pulse[i] ? 1'b1 : clr ? 1'b0 : m_flag[i];
    end
  endtask
  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    chk("cnt0", cnt0, m_cnt[0]); chk("flag0", f0, m_flag[0]); chk("pulse0", p0, m_pulse[0]);
    chk("cnt1", cnt1, m_cnt[1]); chk("flag1", f1, m_flag[1]); chk("pulse1", p1, m_pulse[1]);
  endtask
  task automatic cycs(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  initial begin
    rst = 1; run = 0; gate = 0; intp = 0; ct = 0; tpin = 0; we = 0; clr = 0;
    mode = 2'b00; lval = 0; rval = 0;
    cycs(2);
    chk("rst_cnt", cnt0, 0); chk("rst_flag", f0, 0);
    rst = 0; run = 1;
    // Up free-run wrap at PRESCALE=1
    we = 1; lval = 16'hFFFE; cyc(); we = 0;
    cyc(); chk("t1_ffff", cnt0, 16'hFFFF);
    cyc(); chk("t1_wrap", cnt0, 16'h0000); chk("t1_pulse", p0, 1); chk("t1_flag", f0, 1);
    cyc(); chk("t1_pulse_lo", p0, 0); chk("t1_flag_hold", f0, 1);
    clr = 1; cyc(); clr = 0; chk("t1_clr", f0, 0);
    // Down auto-reload through zero
    run = 0; cyc(); mode = 2'b11; rval = 16'h1234; we = 1; lval = 16'h0001; cyc(); we = 0; run = 1;
    cycs(12); chk("t2_zero", cnt1, 16'h0000);
    cycs(12); chk("t2_reload", cnt1, 16'h1234); chk("t2_pulse", p1, 1);
    cycs(12); chk("t2_dec", cnt1, 16'h1233);
    // Gate qualification
    mode = 2'b00; gate = 1; intp = 1; we = 1; lval = 16'h0010; cyc(); we = 0;
    intp = 0; cycs(5); chk("t3_frozen", cnt0, 16'h0010);
    intp = 1; cycs(3); chk("t3_resume", cnt0, 16'h0013);
    gate = 0;
    // External pin events, one while stopped
    ct = 1; we = 1; lval = 16'h0100; cyc(); we = 0;
    for (int p = 0; p < 3; p++) begin
      run = (p != 1);
      tpin = 1; cycs(2); tpin = 0; cycs(6);
    end
    run = 1;
    chk("t4_ext", cnt0, 16'h0102);
    // Overflow with coincident clear; load beating an overflowing tick
    ct = 0; we = 1; lval = 16'hFFFF; cyc(); we = 0;
    clr = 1; cyc(); clr = 0; chk("t5_setwins", f0, 1);
    we = 1; lval = 16'hFFFF; cyc(); lval = 16'h0055; cyc(); we = 0;
    chk("t5_load", cnt0, 16'h0055); chk("t5_nopulse", p0, 0);
    // Reset mid-count
    mode = 2'b10; we = 1; lval = 16'h00A5; cyc(); we = 0;
    rst = 1; cyc(); rst = 0; chk("t6_rst", cnt0, 0); chk("t6_flag", f0, 0);
    cycs(2); chk("t6_restart", cnt0, 2);
    // Randomised traffic
    for (int n = 0; n < 6000; n++) begin
      rst  = ($urandom_range(0, 299) == 0);
      run  = ($urandom_range(0, 9) != 0);
      gate = ($urandom_range(0, 3) == 0);
      intp = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) ct = ~ct;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      tpin = ($urandom_range(0, 2) == 0) ? ~tpin : tpin;
      we   = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 4))
        0: lval = 16'hFFFF;
        1: lval = 16'h0000;
        2: lval = 16'hFFFD;
        3: lval = 16'h0002;
        default: lval = 16'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) rval = 16'($urandom);
      clr  = ($urandom_range(0, 29) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
